axil_ram_core: RTL and testbench
================================

Name: axil_ram_core

Overview:
- AXI4-Lite slave backed by a single-port-per-channel synchronous RAM. Word-addressed storage, byte-lane write strobes, independent read and write channels.
- Sits behind an AXI-Lite master (e.g. switchboard bridge) as a simple memory target for system and bench use.

Parameters:
- DATA_WIDTH, 32: data bus width in bits; multiple of 8, power of two, at least 8.
- ADDR_WIDTH, 16: byte address width; must exceed log2(DATA_WIDTH/8).
- STRB_WIDTH, DATA_WIDTH/8: byte-lane strobe width; derived, not overridden.
- PIPELINE_OUTPUT, 0: 1 adds one output register stage on the read data path.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- nreset  in  1  synchronous, active-low reset.
- s_axil_awaddr  in  ADDR_WIDTH  write byte address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address accepted.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte enables.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data accepted.
- s_axil_bresp  out  2  always 2'b00 (OKAY).
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response accepted.
- s_axil_araddr  in  ADDR_WIDTH  read byte address.
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address accepted.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  always 2'b00 (OKAY).
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data accepted.

Behaviour:
- Depth is 2^(ADDR_WIDTH - log2(STRB_WIDTH)) words. Word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]. Low byte-offset bits are ignored; no wrap logic is needed, and the full index range is valid.
- Memory initialises to all zeros at time zero. Reset does not clear memory contents.
- Reset (nreset=0 at a clk edge) clears bvalid, rvalid and any pipeline-stage valid. rdata is held at its last value; at time zero it is 0.
- Write channel:
  - awready = wready = awvalid & wvalid & (~bvalid | bready), combinational; both are 0 while nreset=0.
  - AW and W are accepted only together, in the same cycle.
  - On accept, every byte lane i with wstrb[i]=1 is written; other lanes are unchanged. wstrb=0 still produces a response.
  - bvalid rises the cycle after accept and is held until bready. Throughput is one write per cycle when bready is held high.
- Read channel:
  - arready = arvalid & (~rvalid | rready), combinational; 0 in reset.
  - On accept, the word is registered into rdata and rvalid rises the next cycle. rdata/rvalid are held stable until rready.
  - Throughput is one read per cycle with rready high.
  - PIPELINE_OUTPUT=1 inserts a second register stage: latency 2 cycles, with the same hold and backpressure rules.
- Read and write to the same word in the same cycle: the read returns the old (pre-write) data.
- Read and write channels are fully independent; neither stalls the other.
- prot inputs have no effect. Responses are never SLVERR/DECERR.
- Reset mid-transaction drops pending responses; memory writes already committed persist.

Test Plan (DATA_WIDTH=256, ADDR_WIDTH=8 -> 8 words):
- Reset, then read addr 0x00 -> rvalid 1 cycle after arready, rdata=0, rresp=0.
- Write addr 0x20, data pattern P, wstrb all ones -> awready=wready in accept cycle, bvalid next cycle, bresp=0; read 0x20 -> P; read 0x3F -> P (offset ignored).
- Write addr 0x20, data all-FF, wstrb=0x0000_0001 -> read returns P with only byte 0 = 0xFF.
- Hold bready=0 after a write -> bvalid stays 1, awready stays 0 for a new AW+W; bready=1 -> response completes and the next write is accepted.
- Hold rready=0 with rvalid=1 -> rdata stable, arready=0; issue back-to-back reads of 0x00..0xE0 with rready=1 -> one rvalid per cycle, data in order.
- Same-cycle write of Q and read of 0x40 -> read returns old value; subsequent read returns Q; assert nreset=0 with bvalid pending -> bvalid=0 next cycle, Q retained.

Source files
------------

// File: rtl/axil_ram_core.sv
// AXI4-Lite slave backed by a word-addressed synchronous RAM with byte-lane strobes.
// Read and write channels are independent; the read path optionally gets an extra output register.
module axil_ram_core #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int WORD_AW  = ADDR_WIDTH - ADDR_LSB;
    localparam int DEPTH    = 2 ** WORD_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [WORD_AW-1:0] wr_idx;
    logic [WORD_AW-1:0] rd_idx;
    logic               wr_accept;
    logic               rd_accept;
    logic               bvalid_q;
    logic               s1_valid;
    logic               s1_ready;
    logic [DATA_WIDTH-1:0] s1_data = '0;
    logic               unused_inputs;

    // prot and the byte-offset address bits carry no meaning for this target
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

    assign wr_idx = s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];

    // ---------------- write channel ----------------
    assign wr_accept      = nreset & s_axil_awvalid & s_axil_wvalid & (~bvalid_q | s_axil_bready);
    assign s_axil_awready = wr_accept;
    assign s_axil_wready  = wr_accept;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = 2'b00;

    always_ff @(posedge clk) begin
        if (!nreset)
            bvalid_q <= 1'b0;
        else if (wr_accept)
            bvalid_q <= 1'b1;
        else if (s_axil_bready)
            bvalid_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (s_axil_wstrb[i])
                    mem[wr_idx][8*i +: 8] <= s_axil_wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    // Stage 1 is the RAM output register; it reads pre-write contents on a same-word collision.
    assign rd_accept      = nreset & s_axil_arvalid & (~s1_valid | s1_ready);
    assign s_axil_arready = rd_accept;
    assign s_axil_rresp   = 2'b00;

    always_ff @(posedge clk) begin
        if (!nreset)
            s1_valid <= 1'b0;
        else if (rd_accept)
            s1_valid <= 1'b1;
        else if (s1_ready)
            s1_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rd_accept)
            s1_data <= mem[rd_idx];
    end

    generate
        if (PIPELINE_OUTPUT != 0) begin : g_pipe
            logic                  out_valid;
            logic [DATA_WIDTH-1:0] out_data = '0;

            assign s1_ready      = ~out_valid | s_axil_rready;
            assign s_axil_rvalid = out_valid;
            assign s_axil_rdata  = out_data;

            always_ff @(posedge clk) begin
                if (!nreset)
                    out_valid <= 1'b0;
                else if (s1_ready)
                    out_valid <= s1_valid;
            end

            always_ff @(posedge clk) begin
                if (s1_ready && s1_valid)
                    out_data <= s1_data;
            end
        end else begin : g_direct
            assign s1_ready      = s_axil_rready;
            assign s_axil_rvalid = s1_valid;
            assign s_axil_rdata  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_axil_ram_core.sv
// Directed bench for axil_ram_core at DATA_WIDTH=256, ADDR_WIDTH=8 (eight 32-byte words).
module tb_axil_ram_core;

    localparam int DW = 256;
    localparam int AW = 8;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          nreset;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [DW-1:0] model [8];
    logic [DW-1:0] pat_p;
    logic [DW-1:0] pat_q;
    logic [DW-1:0] pat_r;
    logic [DW-1:0] pat_s;
    logic [DW-1:0] ones;

    axil_ram_core #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .PIPELINE_OUTPUT (0)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [SW-1:0] strb);
        for (int b = 0; b < SW; b++)
            if (strb[b]) model[addr[7:5]][8*b +: 8] = data[8*b +: 8];
    endtask

    // Single write with bready held high: accept, one-cycle response, idle.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input string tag);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        check({tag, "_awready"}, DW'(awready), DW'(1));
        check({tag, "_wready"}, DW'(wready), DW'(1));
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(addr, data, strb);
        check({tag, "_bvalid"}, DW'(bvalid), DW'(1));
        check({tag, "_bresp"}, DW'(bresp), DW'(0));
        step();
        check({tag, "_bvalid_clr"}, DW'(bvalid), DW'(0));
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        #1;
        check({tag, "_arready"}, DW'(arready), DW'(1));
        step();
        arvalid = 1'b0;
        check({tag, "_rvalid"}, DW'(rvalid), DW'(1));
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_rresp"}, DW'(rresp), DW'(0));
        step();
        check({tag, "_rvalid_clr"}, DW'(rvalid), DW'(0));
    endtask

    initial begin
        pat_p = {32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF,
                 32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};
        pat_q = {8{32'h5A5A_C3C3}};
        pat_r = {8{32'h1357_9BDF}};
        pat_s = {8{32'hDEAD_BEEF}};
        ones  = '1;
        for (int k = 0; k < 8; k++) model[k] = '0;

        // reset with both channels requesting: nothing may be accepted
        nreset = 1'b0; awprot = 3'b111; arprot = 3'b111;
        awaddr = 8'h00; wdata = ones; wstrb = '1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 8'h00; arvalid = 1'b1; rready = 1'b1;
        step();
        check("rst_awready", DW'(awready), DW'(0));
        check("rst_wready", DW'(wready), DW'(0));
        check("rst_arready", DW'(arready), DW'(0));
        step();
        check("rst_bvalid", DW'(bvalid), DW'(0));
        check("rst_rvalid", DW'(rvalid), DW'(0));
        check("rst_rdata", rdata, '0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        nreset = 1'b1;
        step();

        do_read(8'h00, '0, "rd0_init");

        do_write(8'h20, pat_p, '1, "wr_p");
        do_read(8'h20, pat_p, "rd_p");
        do_read(8'h3F, pat_p, "rd_p_off");

        do_write(8'h20, ones, 32'h0000_0001, "wr_b0");
        do_read(8'h20, {pat_p[DW-1:8], 8'hFF}, "rd_b0");

        do_write(8'h00, ones, '0, "wr_nostrb");
        do_read(8'h00, '0, "rd_nostrb");

        // write backpressure: response held, second AW+W stalled until bready
        awaddr = 8'h80; wdata = pat_s; wstrb = '1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        check("bp_acc1", DW'(awready), DW'(1));
        step();
        model_write(8'h80, pat_s, '1);
        awaddr = 8'h60; wdata = pat_r;
        #1;
        check("bp_bvalid", DW'(bvalid), DW'(1));
        check("bp_awready_stall", DW'(awready), DW'(0));
        check("bp_wready_stall", DW'(wready), DW'(0));
        step();
        check("bp_bvalid_hold", DW'(bvalid), DW'(1));
        check("bp_awready_hold", DW'(awready), DW'(0));
        bready = 1'b1;
        #1;
        check("bp_awready_rel", DW'(awready), DW'(1));
        step();
        model_write(8'h60, pat_r, '1);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_bvalid2", DW'(bvalid), DW'(1));
        step();
        check("bp_bvalid_done", DW'(bvalid), DW'(0));
        do_read(8'h80, pat_s, "rd_s");
        do_read(8'h60, pat_r, "rd_r");

        for (int k = 5; k < 8; k++)
            do_write(AW'(k * 32), {8{32'hC0DE_0000 + 32'(k)}}, '1, "wr_fill");

        // read backpressure: rdata stable, arready low while rvalid && !rready
        araddr = 8'h20; arvalid = 1'b1; rready = 1'b0;
        step();
        araddr = 8'h80;
        #1;
        check("rbp_rvalid", DW'(rvalid), DW'(1));
        check("rbp_rdata", rdata, {pat_p[DW-1:8], 8'hFF});
        check("rbp_arready", DW'(arready), DW'(0));
        step();
        check("rbp_rvalid_hold", DW'(rvalid), DW'(1));
        check("rbp_rdata_hold", rdata, {pat_p[DW-1:8], 8'hFF});
        rready = 1'b1;
        #1;
        check("rbp_arready_rel", DW'(arready), DW'(1));
        step();
        arvalid = 1'b0;
        check("rbp_next", rdata, pat_s);
        step();

        // back-to-back reads, one per cycle
        rready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            araddr = AW'(k * 32); arvalid = 1'b1;
            #1;
            check("b2b_arready", DW'(arready), DW'(1));
            step();
            check("b2b_rvalid", DW'(rvalid), DW'(1));
            check("b2b_rdata", rdata, model[k]);
        end
        arvalid = 1'b0;
        step();
        check("b2b_rvalid_clr", DW'(rvalid), DW'(0));

        // same-cycle write and read of word 2: read sees pre-write data
        awaddr = 8'h40; wdata = pat_q; wstrb = '1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 8'h40; arvalid = 1'b1; rready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_bvalid", DW'(bvalid), DW'(1));
        check("rw_rdata_old", rdata, '0);
        model_write(8'h40, pat_q, '1);
        step();
        do_read(8'h40, pat_q, "rd_q");

        // reset with a pending response drops it; committed data persists
        awaddr = 8'hA0; wdata = pat_r; wstrb = '1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("rst_pend_bvalid", DW'(bvalid), DW'(1));
        nreset = 1'b0;
        step();
        check("rst_drop_bvalid", DW'(bvalid), DW'(0));
        nreset = 1'b1; bready = 1'b1;
        step();
        do_read(8'h40, pat_q, "rd_q_after_rst");
        do_read(8'hA0, pat_r, "rd_a0_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
